// File: rtl/id_hazard_unit_pkg.sv
// Shared types and constants for the ID-stage hazard unit and its mult/div tracker.
package id_hazard_unit_pkg;

    localparam int unsigned MD_CNT_W = 6;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // True when dst is a real register read by the instruction in ID.
    function automatic logic src_match(
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return (dst != REG_ZERO) &&
               ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/id_hazard_unit_muldiv_busy_tracker.sv
// Tracks an in-flight multi-cycle mult/div: accepts an issue, counts down to HI/LO valid.
module muldiv_busy_tracker
    import id_hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_stall,
    input  logic i_cancel,
    output logic o_issue,
    output logic o_busy
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

    md_state_t             r_state;
    md_state_t             w_state_nxt;
    logic [MD_CNT_W-1:0]   r_cnt;
    logic [MD_CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Cancel wins over everything, including a simultaneous start.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_issue     = 1'b0;
        if (i_cancel) begin
            w_state_nxt = MD_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start && !i_stall) begin
                        o_issue     = 1'b1;
                        w_state_nxt = MD_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = MD_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = MD_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard detection: load-use, branch-in-ID dependences and HI/LO-busy stalls,
// plus the mult/div busy tracker and a saturating stall-cycle counter.
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned PERF_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        if_id_instr_rs,
    input  logic [4:0]        if_id_instr_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic              id_reads_hilo,
    input  logic              id_muldiv_start,
    input  logic              id_branch_taken,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_reg_write,
    input  logic [4:0]        id_ex_write_reg_addr,
    input  logic              ex_mem_mem_read,
    input  logic [4:0]        ex_mem_write_reg_addr,
    input  logic              muldiv_cancel,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_flush,
    output logic              if_id_flush,
    output logic              muldiv_issue,
    output logic              hilo_busy,
    output logic [PERF_W-1:0] stall_count
);

    logic              w_match_ex;
    logic              w_match_mem;
    logic              w_load_use;
    logic              w_br_ex;
    logic              w_br_mem;
    logic              w_hilo_stall;
    logic              w_stall;
    logic              w_busy;
    logic [PERF_W-1:0] r_stall_count;

    assign w_match_ex  = src_match(id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt,
                                   id_uses_rs, id_uses_rt);
    assign w_match_mem = src_match(ex_mem_write_reg_addr, if_id_instr_rs, if_id_instr_rt,
                                   id_uses_rs, id_uses_rt);

    assign w_load_use   = id_ex_mem_read && w_match_ex;
    assign w_br_ex      = id_is_branch && id_ex_reg_write && w_match_ex;
    assign w_br_mem     = id_is_branch && ex_mem_mem_read && w_match_mem;
    assign w_hilo_stall = w_busy && (id_reads_hilo || id_muldiv_start);
    assign w_stall      = w_load_use || w_br_ex || w_br_mem || w_hilo_stall;

    assign pc_write    = !w_stall;
    assign if_id_write = !w_stall;
    assign id_ex_flush = w_stall;
    // A stalled branch redirects only once its operands are available.
    assign if_id_flush = id_branch_taken && !w_stall;

    muldiv_busy_tracker #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_busy_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (id_muldiv_start),
        .i_stall  (w_stall),
        .i_cancel (muldiv_cancel),
        .o_issue  (muldiv_issue),
        .o_busy   (w_busy)
    );

    assign hilo_busy = w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + PERF_W'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Scoreboard bench for id_hazard_unit: driver pushes model responses, monitor compares.
module tb_id_hazard_unit;

    localparam int M      = 4;
    localparam int PW     = 4;
    localparam int SC_MAX = (1 << PW) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       is_branch;
        logic       reads_hilo;
        logic       md_start;
        logic       br_taken;
        logic       ex_mem_read;
        logic       ex_reg_write;
        logic [4:0] ex_dst;
        logic       mem_mem_read;
        logic [4:0] mem_dst;
        logic       cancel;
    } stim_t;

    typedef struct packed {
        logic          pc_write;
        logic          if_id_write;
        logic          id_ex_flush;
        logic          if_id_flush;
        logic          issue;
        logic          busy;
        logic [PW-1:0] sc;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    if_id_instr_rs, if_id_instr_rt;
    logic          id_uses_rs, id_uses_rt, id_is_branch, id_reads_hilo;
    logic          id_muldiv_start, id_branch_taken;
    logic          id_ex_mem_read, id_ex_reg_write;
    logic [4:0]    id_ex_write_reg_addr;
    logic          ex_mem_mem_read;
    logic [4:0]    ex_mem_write_reg_addr;
    logic          muldiv_cancel;
    logic          pc_write, if_id_write, id_ex_flush, if_id_flush;
    logic          muldiv_issue, hilo_busy;
    logic [PW-1:0] stall_count;

    resp_t sb[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    cyc      = 0;
    int    busy_end = -1;
    int    nstalls  = 0;

    always #5 clk = ~clk;

    id_hazard_unit #(
        .MULDIV_CYCLES (M),
        .PERF_W        (PW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .if_id_instr_rs        (if_id_instr_rs),
        .if_id_instr_rt        (if_id_instr_rt),
        .id_uses_rs            (id_uses_rs),
        .id_uses_rt            (id_uses_rt),
        .id_is_branch          (id_is_branch),
        .id_reads_hilo         (id_reads_hilo),
        .id_muldiv_start       (id_muldiv_start),
        .id_branch_taken       (id_branch_taken),
        .id_ex_mem_read        (id_ex_mem_read),
        .id_ex_reg_write       (id_ex_reg_write),
        .id_ex_write_reg_addr  (id_ex_write_reg_addr),
        .ex_mem_mem_read       (ex_mem_mem_read),
        .ex_mem_write_reg_addr (ex_mem_write_reg_addr),
        .muldiv_cancel         (muldiv_cancel),
        .pc_write              (pc_write),
        .if_id_write           (if_id_write),
        .id_ex_flush           (id_ex_flush),
        .if_id_flush           (if_id_flush),
        .muldiv_issue          (muldiv_issue),
        .hilo_busy             (hilo_busy),
        .stall_count           (stall_count)
    );

    function automatic logic uses(input logic [4:0] d, input stim_t s);
        return (d != 5'd0) && ((s.uses_rs && s.rs == d) || (s.uses_rt && s.rt == d));
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n        = ($urandom_range(0, 99) >= 1);
        s.rs           = 5'($urandom_range(0, 3));
        s.rt           = 5'($urandom_range(0, 3));
        s.uses_rs      = ($urandom_range(0, 99) < 70);
        s.uses_rt      = ($urandom_range(0, 99) < 50);
        s.is_branch    = ($urandom_range(0, 99) < 30);
        s.reads_hilo   = ($urandom_range(0, 99) < 20);
        s.md_start     = ($urandom_range(0, 99) < 20);
        s.br_taken     = ($urandom_range(0, 99) < 25);
        s.ex_mem_read  = ($urandom_range(0, 99) < 30);
        s.ex_reg_write = ($urandom_range(0, 99) < 60);
        s.ex_dst       = 5'($urandom_range(0, 3));
        s.mem_mem_read = ($urandom_range(0, 99) < 30);
        s.mem_dst      = 5'($urandom_range(0, 3));
        s.cancel       = ($urandom_range(0, 99) < 5);
        return s;
    endfunction

    // Reference: mult/div busy is an interval of cycle numbers, stall count is a plain tally.
    task automatic apply(input stim_t s);
        resp_t e;
        logic  busy, stall, issue;
        @(posedge clk);
        #1;
        rst_n                 = s.rst_n;
        if_id_instr_rs        = s.rs;
        if_id_instr_rt        = s.rt;
        id_uses_rs            = s.uses_rs;
        id_uses_rt            = s.uses_rt;
        id_is_branch          = s.is_branch;
        id_reads_hilo         = s.reads_hilo;
        id_muldiv_start       = s.md_start;
        id_branch_taken       = s.br_taken;
        id_ex_mem_read        = s.ex_mem_read;
        id_ex_reg_write       = s.ex_reg_write;
        id_ex_write_reg_addr  = s.ex_dst;
        ex_mem_mem_read       = s.mem_mem_read;
        ex_mem_write_reg_addr = s.mem_dst;
        muldiv_cancel         = s.cancel;
        if (!s.rst_n) begin
            busy_end = -1;
            nstalls  = 0;
        end
        busy  = (cyc <= busy_end);
        stall = (s.ex_mem_read && uses(s.ex_dst, s))
             || (s.is_branch && s.ex_reg_write && uses(s.ex_dst, s))
             || (s.is_branch && s.mem_mem_read && uses(s.mem_dst, s))
             || (busy && (s.reads_hilo || s.md_start));
        issue = !busy && s.md_start && !stall && !s.cancel;
        e.pc_write    = !stall;
        e.if_id_write = !stall;
        e.id_ex_flush = stall;
        e.if_id_flush = s.br_taken && !stall;
        e.issue       = issue;
        e.busy        = busy;
        e.sc          = PW'((nstalls > SC_MAX) ? SC_MAX : nstalls);
        sb.push_back(e);
        if (s.rst_n) begin
            if (stall) nstalls++;
            if (s.cancel) busy_end = cyc;
            else if (issue) busy_end = cyc + M;
        end
        cyc++;
    endtask

    always @(negedge clk) begin
        resp_t exp_r, got;
        if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            got   = {pc_write, if_id_write, id_ex_flush, if_id_flush,
                     muldiv_issue, hilo_busy, stall_count};
            n_vec++;
            if (got !== exp_r) begin
                n_miss++;
                $display("FAIL vec%0d outputs: got pcw=%b ifw=%b exfl=%b iffl=%b iss=%b busy=%b sc=%0d, exp pcw=%b ifw=%b exfl=%b iffl=%b iss=%b busy=%b sc=%0d",
                         n_vec, got.pc_write, got.if_id_write, got.id_ex_flush, got.if_id_flush,
                         got.issue, got.busy, got.sc, exp_r.pc_write, exp_r.if_id_write,
                         exp_r.id_ex_flush, exp_r.if_id_flush, exp_r.issue, exp_r.busy, exp_r.sc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        s = idle(); s.rst_n = 1'b0;
        apply(s);
        apply(s);
        apply(idle());

        // Load-use: LW $8 in EX, ADD rs=8 in ID; then the load moves to MEM.
        s = idle(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_dst = 8; s.rs = 8; s.uses_rs = 1;
        apply(s);
        s = idle(); s.mem_mem_read = 1; s.mem_dst = 8; s.rs = 8; s.uses_rs = 1;
        apply(s);
        // $zero destination never hazards.
        s = idle(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_dst = 0; s.rs = 0; s.uses_rs = 1;
        apply(s);

        // LW $9 feeding BEQ rt=9: br_ex, then br_mem, then redirect.
        s = idle(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_dst = 9;
        s.is_branch = 1; s.rt = 9; s.uses_rt = 1; s.br_taken = 1;
        apply(s);
        s = idle(); s.mem_mem_read = 1; s.mem_dst = 9;
        s.is_branch = 1; s.rt = 9; s.uses_rt = 1; s.br_taken = 1;
        apply(s);
        s = idle(); s.is_branch = 1; s.rt = 9; s.uses_rt = 1; s.br_taken = 1;
        apply(s);

        // MULT then MFLO waiting out the busy window.
        s = idle(); s.md_start = 1;
        apply(s);
        s = idle(); s.reads_hilo = 1;
        for (int i = 0; i < M + 1; i++) apply(s);

        // Back-to-back mult/div.
        s = idle(); s.md_start = 1;
        for (int i = 0; i < M + 3; i++) apply(s);
        for (int i = 0; i < M + 1; i++) apply(idle());

        // Cancel in the second busy cycle together with a new start.
        s = idle(); s.md_start = 1;
        apply(s);
        apply(idle());
        s = idle(); s.md_start = 1; s.cancel = 1;
        apply(s);
        apply(idle());
        apply(idle());

        // Saturation of the stall counter.
        s = idle(); s.ex_mem_read = 1; s.ex_dst = 3; s.rs = 3; s.uses_rs = 1;
        for (int i = 0; i < 20; i++) apply(s);

        // Reset asserted mid-BUSY.
        s = idle(); s.md_start = 1;
        apply(s);
        apply(idle());
        s = idle(); s.rst_n = 1'b0;
        apply(s);
        apply(s);
        apply(idle());
        apply(idle());

        for (int i = 0; i < 1500; i++) apply(rand_stim());
        apply(idle());

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d responses left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
